// File: rtl/display_pkg.sv
// Shared types, segment patterns and the hex/BCD digit decoder for the
// multiplexed 7-segment driver.
package display_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ESCREVE  = 2'd2
  } estado_t;

  // Segment order is a..g, index 0 = a, active-high
  localparam logic [0:6] SEG_0       = 7'b1111110;
  localparam logic [0:6] SEG_1       = 7'b0110000;
  localparam logic [0:6] SEG_2       = 7'b1101101;
  localparam logic [0:6] SEG_3       = 7'b1111001;
  localparam logic [0:6] SEG_4       = 7'b0110011;
  localparam logic [0:6] SEG_5       = 7'b1011011;
  localparam logic [0:6] SEG_6       = 7'b1011111;
  localparam logic [0:6] SEG_7       = 7'b1110000;
  localparam logic [0:6] SEG_8       = 7'b1111111;
  localparam logic [0:6] SEG_9       = 7'b1111011;
  localparam logic [0:6] SEG_A       = 7'b1110111;
  localparam logic [0:6] SEG_B       = 7'b0011111;
  localparam logic [0:6] SEG_C       = 7'b1001110;
  localparam logic [0:6] SEG_D       = 7'b0111101;
  localparam logic [0:6] SEG_E       = 7'b1001111;
  localparam logic [0:6] SEG_F       = 7'b1000111;
  localparam logic [0:6] SEG_TRACO   = 7'b0000001;
  localparam logic [0:6] SEG_APAGADO = 7'b0000000;

  function automatic logic [0:6] decod_7seg(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin_para_bcd.sv
// Sequential shift-add-3 binary to BCD converter, one step per clock.
// Overflow is decided from the loaded value, so truncated BCD never matters.
module bin_para_bcd
  import display_pkg::*;
#(
  parameter int LARGURA   = 14,
  parameter int N_DIGITOS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     valor,
  output logic                   pronto,
  output logic [4*N_DIGITOS-1:0] bcd,
  output logic                   estouro
);

  localparam int CW = $clog2(LARGURA + 1);

  function automatic logic [63:0] maximo_decimal(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] LIMITE = maximo_decimal(N_DIGITOS);

  logic [LARGURA-1:0]     bin;
  logic [CW-1:0]          passos;
  logic [4*N_DIGITOS-1:0] bcd_aj;

  always_comb begin
    bcd_aj = bcd;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_aj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin     <= '0;
      bcd     <= '0;
      passos  <= '0;
      estouro <= 1'b0;
    end else if (inicio) begin
      bin     <= valor;
      bcd     <= '0;
      passos  <= CW'(LARGURA);
      estouro <= (64'(valor) > LIMITE);
    end else if (passos != '0) begin
      bcd    <= {bcd_aj[4*N_DIGITOS-2:0], bin[LARGURA-1]};
      bin    <= bin << 1;
      passos <= passos - CW'(1);
    end
  end

  // High during the cycle whose closing edge performs the final shift
  assign pronto = (passos == CW'(1));

endmodule

// File: rtl/display_7seg_multiplexado.sv
// Multi-digit 7-segment driver: load FSM, display register with leading-zero
// blanking, and a free-running digit scan onto a shared segment bus.
module display_7seg_multiplexado
  import display_pkg::*;
#(
  parameter int N_DIGITOS     = 4,
  parameter int LARGURA       = 14,
  parameter int DIV_VARREDURA = 50000,
  parameter int ANODO_COMUM   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LARGURA-1:0]   valor,
  input  logic                 carregar,
  input  logic                 modo_hex,
  input  logic                 apagar_zeros,
  output logic                 ocupado,
  output logic [0:6]           segmentos,
  output logic [N_DIGITOS-1:0] digito_sel
);

  localparam int LD = 4 * N_DIGITOS;
  localparam int LP = (LARGURA > LD) ? LARGURA : LD;
  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int PW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;

  estado_t estado, estado_prox;

  logic [LARGURA-1:0]   valor_reg;
  logic                 modo_hex_reg;
  logic                 apagar_reg;
  logic                 inicio, carga, commit;
  logic                 pronto;
  logic [LD-1:0]        bcd;
  logic                 estouro_dec;

  logic [LD-1:0]        disp_digitos;
  logic [N_DIGITOS-1:0] disp_apaga;
  logic                 disp_traco;

  logic [LP-1:0]        valor_ext;
  logic                 estouro_hex;
  logic [LD-1:0]        novos_digitos;
  logic                 novo_traco;
  logic [N_DIGITOS-1:0] novo_apaga;
  logic                 zeros_acima;

  logic [PW-1:0]        presc;
  logic [IW-1:0]        idx;
  logic [0:6]           seg_ativo;
  logic [N_DIGITOS-1:0] sel_ativo;

  bin_para_bcd #(
    .LARGURA   (LARGURA),
    .N_DIGITOS (N_DIGITOS)
  ) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .inicio  (inicio),
    .valor   (valor),
    .pronto  (pronto),
    .bcd     (bcd),
    .estouro (estouro_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    inicio      = 1'b0;
    carga       = 1'b0;
    commit      = 1'b0;
    case (estado)
      OCIOSO: begin
        if (carregar) begin
          carga       = 1'b1;
          inicio      = !modo_hex;
          estado_prox = modo_hex ? ESCREVE : CONVERTE;
        end
      end
      CONVERTE: begin
        if (pronto) estado_prox = ESCREVE;
      end
      ESCREVE: begin
        commit      = 1'b1;
        estado_prox = OCIOSO;
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  assign ocupado = (estado != OCIOSO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor_reg    <= '0;
      modo_hex_reg <= 1'b0;
      apagar_reg   <= 1'b0;
    end else if (carga) begin
      valor_reg    <= valor;
      modo_hex_reg <= modo_hex;
      apagar_reg   <= apagar_zeros;
    end
  end

  // Zero-extend so narrow values still fill every hex digit
  assign valor_ext   = LP'(valor_reg);
  assign estouro_hex = |(valor_ext >> LD);

  always_comb begin
    novos_digitos = modo_hex_reg ? valor_ext[LD-1:0] : bcd;
    novo_traco    = modo_hex_reg ? estouro_hex : estouro_dec;
    novo_apaga    = '0;
    zeros_acima   = 1'b1;
    for (int i = N_DIGITOS - 1; i >= 1; i--) begin
      zeros_acima   = zeros_acima && (novos_digitos[4*i +: 4] == 4'd0);
      novo_apaga[i] = apagar_reg && zeros_acima;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_digitos <= '0;
      disp_apaga   <= '0;
      disp_traco   <= 1'b0;
    end else if (commit) begin
      disp_digitos <= novos_digitos;
      disp_apaga   <= novo_apaga;
      disp_traco   <= novo_traco;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(DIV_VARREDURA - 1)) begin
      presc <= '0;
      idx   <= (idx == IW'(N_DIGITOS - 1)) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_comb begin
    if (disp_traco)           seg_ativo = SEG_TRACO;
    else if (disp_apaga[idx]) seg_ativo = SEG_APAGADO;
    else                      seg_ativo = decod_7seg(disp_digitos[4*idx +: 4]);
    sel_ativo = N_DIGITOS'(1) << idx;
  end

  assign segmentos  = (ANODO_COMUM != 0) ? ~seg_ativo : seg_ativo;
  assign digito_sel = (ANODO_COMUM != 0) ? ~sel_ativo : sel_ativo;

endmodule

// File: tb/tb_display_7seg_multiplexado.sv
// Directed bench: one common-cathode and one common-anode instance share stimulus.
module tb_display_7seg_multiplexado;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] valor;
  logic        carregar, modo_hex, apagar_zeros;
  logic        ocupado_a, ocupado_i;
  logic [0:6]  seg_a, seg_i;
  logic [3:0]  sel_a, sel_i;

  int testes = 0;
  int falhas = 0;
  int ciclos;

  display_7seg_multiplexado #(
    .N_DIGITOS(4), .LARGURA(14), .DIV_VARREDURA(4), .ANODO_COMUM(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valor(valor), .carregar(carregar),
    .modo_hex(modo_hex), .apagar_zeros(apagar_zeros),
    .ocupado(ocupado_a), .segmentos(seg_a), .digito_sel(sel_a)
  );

  display_7seg_multiplexado #(
    .N_DIGITOS(4), .LARGURA(14), .DIV_VARREDURA(4), .ANODO_COMUM(1)
  ) dut_inv (
    .clk(clk), .rst_n(rst_n), .valor(valor), .carregar(carregar),
    .modo_hex(modo_hex), .apagar_zeros(apagar_zeros),
    .ocupado(ocupado_i), .segmentos(seg_i), .digito_sel(sel_i)
  );

  always #5 clk = ~clk;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    testes++;
    assert (obs === esp) else begin
      falhas++;
      $error("FAIL %s observado=%0h esperado=%0h", tag, obs, esp);
    end
  endtask

  // Waits (bounded) until digit i is selected, then checks its segment pattern
  task automatic verifica_digito(input bit inv, input int i, input logic [6:0] esp, input string tag);
    logic [3:0] alvo;
    logic [3:0] sel;
    logic [6:0] seg;
    int n;
    alvo = 4'b0001 << i;
    if (inv) alvo = ~alvo;
    n = 0;
    sel = inv ? sel_i : sel_a;
    while (sel !== alvo && n < 40) begin
      @(negedge clk);
      n++;
      sel = inv ? sel_i : sel_a;
    end
    seg = inv ? seg_i : seg_a;
    verifica({tag, "_sel"}, {28'b0, sel}, {28'b0, alvo});
    verifica(tag, {25'b0, seg}, {25'b0, esp});
  endtask

  task automatic carrega(input logic [13:0] v, input logic hex, input logic apaga, output int n);
    valor = v;
    modo_hex = hex;
    apagar_zeros = apaga;
    carregar = 1'b1;
    @(negedge clk);
    carregar = 1'b0;
    n = 0;
    while (ocupado_a === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valor = '0;
    carregar = 1'b0;
    modo_hex = 1'b0;
    apagar_zeros = 1'b0;
    repeat (3) @(negedge clk);

    verifica("reset_ocupado", {31'b0, ocupado_a}, 32'd0);
    verifica("reset_sel", {28'b0, sel_a}, 32'h1);
    verifica("reset_seg", {25'b0, seg_a}, {25'b0, 7'b1111110});
    verifica("reset_sel_inv", {28'b0, sel_i}, 32'he);

    rst_n = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      verifica("scan_sel", {28'b0, sel_a}, 32'h1 << ((j / 4) % 4));
      verifica("scan_seg", {25'b0, seg_a}, {25'b0, 7'b1111110});
      @(negedge clk);
    end

    carrega(14'd1234, 1'b0, 1'b1, ciclos);
    verifica("dec_ocupado_ciclos", ciclos, 32'd15);
    verifica_digito(0, 0, 7'b0110011, "d1234_0");
    verifica_digito(0, 1, 7'b1111001, "d1234_1");
    verifica_digito(0, 2, 7'b1101101, "d1234_2");
    verifica_digito(0, 3, 7'b0110000, "d1234_3");

    carrega(14'd7, 1'b0, 1'b1, ciclos);
    verifica_digito(0, 0, 7'b1110000, "d7_0");
    verifica_digito(0, 1, 7'b0000000, "d7_1");
    verifica_digito(0, 2, 7'b0000000, "d7_2");
    verifica_digito(0, 3, 7'b0000000, "d7_3");

    carrega(14'd0, 1'b0, 1'b1, ciclos);
    verifica_digito(0, 0, 7'b1111110, "d0_0");
    verifica_digito(0, 1, 7'b0000000, "d0_1");
    verifica_digito(0, 3, 7'b0000000, "d0_3");

    carrega(14'h2BEF, 1'b1, 1'b0, ciclos);
    verifica("hex_ocupado_ciclos", ciclos, 32'd1);
    verifica_digito(0, 0, 7'b1000111, "h2bef_0");
    verifica_digito(0, 1, 7'b1001111, "h2bef_1");
    verifica_digito(0, 2, 7'b0011111, "h2bef_2");
    verifica_digito(0, 3, 7'b1101101, "h2bef_3");

    carrega(14'd12000, 1'b0, 1'b1, ciclos);
    verifica_digito(0, 0, 7'b0000001, "ovf_0");
    verifica_digito(0, 2, 7'b0000001, "ovf_2");
    verifica_digito(0, 3, 7'b0000001, "ovf_3");

    // Strobe held into the ESCREVE cycle: second value must be ignored
    valor = 14'h00A5;
    modo_hex = 1'b1;
    apagar_zeros = 1'b0;
    carregar = 1'b1;
    @(negedge clk);
    verifica("escreve_ocupado", {31'b0, ocupado_a}, 32'd1);
    valor = 14'h1234;
    @(negedge clk);
    carregar = 1'b0;
    verifica("escreve_ignora", {31'b0, ocupado_a}, 32'd0);
    verifica_digito(0, 0, 7'b1011011, "ha5_0");
    verifica_digito(0, 1, 7'b1110111, "ha5_1");
    verifica_digito(0, 2, 7'b1111110, "ha5_2");

    // Second strobe mid-conversion
    valor = 14'd4321;
    modo_hex = 1'b0;
    carregar = 1'b1;
    @(negedge clk);
    carregar = 1'b0;
    repeat (4) @(negedge clk);
    valor = 14'd9999;
    carregar = 1'b1;
    @(negedge clk);
    carregar = 1'b0;
    ciclos = 0;
    while (ocupado_a === 1'b1 && ciclos < 100) begin
      ciclos++;
      @(negedge clk);
    end
    verifica("meio_ocupado_ciclos", ciclos, 32'd10);
    verifica_digito(0, 0, 7'b0110000, "d4321_0");
    verifica_digito(0, 1, 7'b1101101, "d4321_1");
    verifica_digito(0, 2, 7'b1111001, "d4321_2");
    verifica_digito(0, 3, 7'b0110011, "d4321_3");

    // Reset during a conversion
    valor = 14'd1234;
    apagar_zeros = 1'b1;
    carregar = 1'b1;
    @(negedge clk);
    carregar = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    verifica("rst_meio_ocupado", {31'b0, ocupado_a}, 32'd0);
    verifica("rst_meio_sel", {28'b0, sel_a}, 32'h1);
    verifica("rst_meio_seg", {25'b0, seg_a}, {25'b0, 7'b1111110});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    verifica("rst_meio_depois", {31'b0, ocupado_a}, 32'd0);
    verifica_digito(0, 1, 7'b1111110, "rst_1");
    verifica_digito(0, 3, 7'b1111110, "rst_3");

    carrega(14'd8, 1'b0, 1'b1, ciclos);
    verifica_digito(1, 0, 7'b0000000, "inv8_0");
    verifica_digito(1, 1, 7'b1111111, "inv8_1");
    verifica_digito(0, 0, 7'b1111111, "dir8_0");

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
